encoder_pipe: RTL and testbench

Parametrised, registered successor to the 4-to-2 combinational encoder (encoder_gate).
- Accepts an N_IN-bit request vector over a valid/ready handshake and returns the encoded index one cycle later.
- Runtime-selectable fixed-priority or round-robin arbitration.
- Flags zero-hot and multi-hot inputs and keeps a saturating error count.
- Sits between request sources and any consumer that needs a binary channel index.

---
 rtl/encoder_pkg.sv | 14 +
 rtl/encoder_pipe_prio_pick.sv | 37 +++
 rtl/encoder_pipe.sv | 83 ++++++++
 tb/tb_encoder_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared definitions for the registered request encoder.
package encoder_pkg;

    // Arbitration mode encoding for the rr_en input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for n requests, never below one bit so a degenerate
    // single-input build still has a legal vector width.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/encoder_pipe_prio_pick.sv
// Combinational picker: first set bit of vec at or after start, wrapping
// from N-1 back to 0. start must be below N. idx is 0 when vec is all zero.
module prio_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] shifted;
    logic [N-1:0]   rot;
    logic [W:0]     sum;

    // Rotate so start lands at bit 0, take the lowest set bit, then map
    // the offset back to an absolute index with an explicit modulo-N fold.
    always_comb begin
        dbl     = {vec, vec};
        shifted = dbl >> start;
        rot     = shifted[N-1:0];
        sum     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, start} + (W+1)'(i);
            end
        end
        if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
        end
        found = |vec;
        idx   = sum[W-1:0];
    end

endmodule

// File: rtl/encoder_pipe.sv
// Registered N_IN-way request encoder with fixed-priority or round-robin
// arbitration, zero-hot/multi-hot flags and a saturating error counter.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready = !out_valid || out_ready, so a held result blocks
// new input and a consumed result can be replaced in the same cycle.
module encoder_pipe
    import encoder_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int W_OUT = idx_width(N_IN),
    parameter int W_ERR = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IN-1:0]   req_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              rr_en,
    output logic [W_OUT-1:0]  num,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              none,
    output logic              multi,
    output logic [W_ERR-1:0]  err_cnt
);

    logic [W_OUT-1:0] ptr;
    logic [W_OUT-1:0] start;
    logic [W_OUT-1:0] pick;
    logic             found;
    logic             accept;
    logic             is_multi;
    logic             is_err;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign start    = (rr_en == MODE_RR) ? ptr : '0;
    assign is_multi = (req_in & (req_in - N_IN'(1))) != '0;
    assign is_err   = is_multi || !found;

    prio_pick #(
        .N (N_IN),
        .W (W_OUT)
    ) u_pick (
        .vec   (req_in),
        .start (start),
        .idx   (pick),
        .found (found)
    );

    // Output register stage: load on accept, drop valid on a bare consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            num       <= '0;
            none      <= 1'b0;
            multi     <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            num       <= pick;
            none      <= !found;
            multi     <= is_multi;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Round-robin pointer and saturating error count, both advanced on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            err_cnt <= '0;
        end else if (accept) begin
            if (rr_en == MODE_RR && found) begin
                ptr <= (pick == W_OUT'(N_IN - 1)) ? '0 : pick + W_OUT'(1);
            end
            if (is_err && err_cnt != '1) begin
                err_cnt <= err_cnt + W_ERR'(1);
            end
        end
    end

endmodule

// File: tb/tb_encoder_pipe.sv
// Bench for encoder_pipe: a 4-input instance with a 2-bit error counter and
// a 5-input instance for the non-power-of-two wrap.
module tb_encoder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT A: N_IN=4, W_ERR=2 ----------------
    logic       rst_a = 1'b1;
    logic [3:0] req_a = '0;
    logic       valid_a = 1'b0;
    logic       in_ready_a;
    logic       rr_a = 1'b0;
    logic [1:0] num_a;
    logic       out_valid_a;
    logic       out_ready_a = 1'b1;
    logic       none_a;
    logic       multi_a;
    logic [1:0] err_a;
    logic [5:0] exp_q_a[$];

    encoder_pipe #(.N_IN(4), .W_ERR(2)) dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .req_in    (req_a),
        .in_valid  (valid_a),
        .in_ready  (in_ready_a),
        .rr_en     (rr_a),
        .num       (num_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .none      (none_a),
        .multi     (multi_a),
        .err_cnt   (err_a)
    );

    // ---------------- DUT B: N_IN=5, W_ERR=8 ----------------
    logic        rst_b = 1'b1;
    logic [4:0]  req_b = '0;
    logic        valid_b = 1'b0;
    logic        in_ready_b;
    logic        rr_b = 1'b0;
    logic [2:0]  num_b;
    logic        out_valid_b;
    logic        out_ready_b = 1'b1;
    logic        none_b;
    logic        multi_b;
    logic [7:0]  err_b;
    logic [12:0] exp_q_b[$];

    encoder_pipe #(.N_IN(5), .W_ERR(8)) dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .req_in    (req_b),
        .in_valid  (valid_b),
        .in_ready  (in_ready_b),
        .rr_en     (rr_b),
        .num       (num_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .none      (none_b),
        .multi     (multi_b),
        .err_cnt   (err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] mk_a(input int n, input bit nn, input bit m, input int e);
        return {n[1:0], nn, m, e[1:0]};
    endfunction

    function automatic logic [12:0] mk_b(input int n, input bit nn, input bit m, input int e);
        return {n[2:0], nn, m, e[7:0]};
    endfunction

    // Monitors: pop and compare whenever a result is handed over.
    always @(negedge clk) begin
        if (!rst_a && out_valid_a && out_ready_a) begin
            if (exp_q_a.size() == 0) begin
                chk("a_unexpected_output", 32'd1, 32'd0);
            end else begin
                chk("a_result", {num_a, none_a, multi_a, err_a}, exp_q_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && out_valid_b && out_ready_b) begin
            if (exp_q_b.size() == 0) begin
                chk("b_unexpected_output", 32'd1, 32'd0);
            end else begin
                chk("b_result", {num_b, none_b, multi_b, err_b}, exp_q_b.pop_front());
            end
        end
    end

    // Present one vector on A, wait for acceptance, queue its expected result.
    // Returns 1 time unit after the accepting edge with in_valid still high.
    task automatic send_a(input logic [3:0] req, input logic rr, input logic [5:0] exp);
        bit acc;
        int cyc;
        req_a   = req;
        rr_a    = rr;
        valid_a = 1'b1;
        acc     = 1'b0;
        cyc     = 0;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = in_ready_a;
            if (acc) exp_q_a.push_back(exp);
            @(posedge clk);
            cyc++;
        end
        if (!acc) chk("a_accept_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic send_b(input logic [4:0] req, input logic rr, input logic [12:0] exp);
        bit acc;
        int cyc;
        req_b   = req;
        rr_b    = rr;
        valid_b = 1'b1;
        acc     = 1'b0;
        cyc     = 0;
        while (!acc && cyc < 50) begin
            @(negedge clk);
            acc = in_ready_b;
            if (acc) exp_q_b.push_back(exp);
            @(posedge clk);
            cyc++;
        end
        if (!acc) chk("b_accept_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic reset_a();
        valid_a = 1'b0;
        rst_a   = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
    endtask

    task automatic drain();
        int cyc = 0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        while ((exp_q_a.size() != 0 || exp_q_b.size() != 0) && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    initial begin
        // Reset both instances for two cycles.
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("a_reset_state", {out_valid_a, num_a, none_a, multi_a, err_a, in_ready_a}, 8'b0_00_0_0_00_1);
        chk("b_reset_state", {out_valid_b, num_b, none_b, multi_b, err_b}, 14'd0);
        @(posedge clk);
        #1;

        // One-hot sweep, fixed priority, back to back.
        send_a(4'b0001, 1'b0, mk_a(0, 0, 0, 0));
        send_a(4'b0010, 1'b0, mk_a(1, 0, 0, 0));
        send_a(4'b0100, 1'b0, mk_a(2, 0, 0, 0));
        send_a(4'b1000, 1'b0, mk_a(3, 0, 0, 0));
        // Fixed priority multi-hot, then zero vector.
        send_a(4'b1010, 1'b0, mk_a(1, 0, 1, 1));
        send_a(4'b0000, 1'b0, mk_a(0, 1, 0, 2));
        drain();
        reset_a();

        // Round-robin wrap; error count also saturates at 3 here.
        send_a(4'b1111, 1'b1, mk_a(0, 0, 1, 1));
        send_a(4'b1111, 1'b1, mk_a(1, 0, 1, 2));
        send_a(4'b1111, 1'b1, mk_a(2, 0, 1, 3));
        send_a(4'b1111, 1'b1, mk_a(3, 0, 1, 3));
        send_a(4'b1111, 1'b1, mk_a(0, 0, 1, 3));
        send_a(4'b0000, 1'b1, mk_a(0, 1, 0, 3));
        send_a(4'b1111, 1'b1, mk_a(1, 0, 1, 3));
        // Fixed-mode accept must ignore and keep ptr (now 2).
        send_a(4'b1100, 1'b0, mk_a(2, 0, 1, 3));
        send_a(4'b0111, 1'b1, mk_a(2, 0, 1, 3));
        drain();
        reset_a();

        // Backpressure: hold for three cycles, then consume and accept together.
        send_a(4'b0100, 1'b0, mk_a(2, 0, 0, 0));
        out_ready_a = 1'b0;
        req_a       = 4'b0001;
        valid_a     = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready_a, 0);
            chk("bp_hold", {out_valid_a, num_a}, 3'b1_10);
        end
        @(posedge clk);
        #1;
        out_ready_a = 1'b1;
        exp_q_a.push_back(mk_a(0, 0, 0, 0));
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        @(negedge clk);
        chk("bp_no_bubble", out_valid_a, 1);
        drain();
        reset_a();

        // Saturation with zero vectors.
        send_a(4'b0000, 1'b0, mk_a(0, 1, 0, 1));
        send_a(4'b0000, 1'b0, mk_a(0, 1, 0, 2));
        send_a(4'b0000, 1'b0, mk_a(0, 1, 0, 3));
        send_a(4'b0000, 1'b0, mk_a(0, 1, 0, 3));
        send_a(4'b0000, 1'b0, mk_a(0, 1, 0, 3));
        // Move ptr to 1 before the mid-operation reset.
        send_a(4'b1111, 1'b1, mk_a(0, 0, 1, 3));
        drain();

        // Reset while a result is pending: it must vanish.
        out_ready_a = 1'b0;
        send_a(4'b0001, 1'b0, mk_a(0, 0, 0, 3));
        valid_a = 1'b0;
        @(negedge clk);
        chk("rst_pending_valid", out_valid_a, 1);
        @(posedge clk);
        #1;
        reset_a();
        void'(exp_q_a.pop_back());
        @(negedge clk);
        chk("rst_clears", {out_valid_a, err_a}, 3'b0_00);
        @(posedge clk);
        #1;
        out_ready_a = 1'b1;
        send_a(4'b1111, 1'b1, mk_a(0, 0, 1, 1));
        drain();

        // Non-power-of-two wrap on B.
        send_b(5'b10001, 1'b1, mk_b(0, 0, 1, 1));
        send_b(5'b10001, 1'b1, mk_b(4, 0, 1, 2));
        send_b(5'b10001, 1'b1, mk_b(0, 0, 1, 3));
        send_b(5'b10001, 1'b1, mk_b(4, 0, 1, 4));
        send_b(5'b10000, 1'b0, mk_b(4, 0, 0, 4));
        send_b(5'b00000, 1'b1, mk_b(0, 1, 0, 5));
        send_b(5'b01110, 1'b1, mk_b(1, 0, 1, 6));
        drain();

        chk("a_queue_empty", exp_q_a.size(), 0);
        chk("b_queue_empty", exp_q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
